// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encodings, stall-vector
// bit positions and small helpers.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBUS = 2'd1,
        ST_IBUS = 2'd2
    } arb_state_e;

    localparam int STALL_IF  = 1;
    localparam int STALL_MEM = 4;

    localparam logic [3:0] SEL_ALL = 4'hF;

    function automatic logic in_flight(input arb_state_e s);
        return (s == ST_DBUS) || (s == ST_IBUS);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External single-port memory bus: the arbiter drives it as master, the
// memory answers as slave.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [3:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, sel, addr, wdata, input ack, rdata);
    modport slave  (input req, we, sel, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_bus_watchdog.sv
// Bus watchdog: counts cycles of an in-flight transfer without ack and flags
// a timeout on the cycle the count would reach TIMEOUT (TIMEOUT=0 disables).
module mem_bus_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic timeout
);
    localparam bit            WD_EN   = (TIMEOUT > 0);
    localparam logic [TOW-1:0] CNT_LAST = TOW'(TIMEOUT - 1);

    logic [TOW-1:0] cnt_q;
    logic [TOW-1:0] cnt_d;

    // Next counter value: clear on transfer start, count while waiting.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active && !ack) begin
            cnt_d = cnt_q + TOW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign timeout = WD_EN && active && !ack && (cnt_q == CNT_LAST);

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access (data has
// priority at idle decision points) and holds each result until its stage advances.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TOW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_inst,
    output logic              if_stall_req,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_sel,
    input  logic [AW-1:0]     dm_addr,
    input  logic [DW-1:0]     dm_wdata,
    output logic [DW-1:0]     dm_rdata,
    output logic              dm_stall_req,
    mem_bus_arbiter_if.master bus,
    output logic              bus_err
);
    arb_state_e    state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [3:0]    bus_sel_q, bus_sel_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [DW-1:0] if_inst_q, if_inst_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          d_done_q, d_done_d;
    logic          i_done_q, i_done_d;
    logic          bus_err_q, bus_err_d;

    logic          busy_s;
    logic          wd_start_s;
    logic          wd_timeout_s;
    logic          cmpl_s;
    logic [DW-1:0] rdata_s;
    logic          unused_stall_s;

    assign unused_stall_s = ^{stall_i[5], stall_i[3:2], stall_i[0]};

    assign busy_s  = in_flight(state_q);
    assign cmpl_s  = busy_s && (bus.ack || wd_timeout_s);
    assign rdata_s = bus.ack ? bus.rdata : '0;

    mem_bus_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (wd_start_s),
        .active  (busy_s),
        .ack     (bus.ack),
        .timeout (wd_timeout_s)
    );

    // Next-state logic; done flags clear first so a same-cycle set wins.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_inst_d   = if_inst_q;
        dm_rdata_d  = dm_rdata_q;
        d_done_d    = d_done_q;
        i_done_d    = i_done_q;
        wd_start_s  = 1'b0;

        if (!stall_i[STALL_MEM]) begin
            d_done_d = 1'b0;
        end else begin
            d_done_d = d_done_q;
        end
        if (!stall_i[STALL_IF]) begin
            i_done_d = 1'b0;
        end else begin
            i_done_d = i_done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (dm_req && !d_done_q) begin
                    state_d     = ST_DBUS;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_we;
                    bus_sel_d   = dm_sel;
                    bus_addr_d  = dm_addr;
                    bus_wdata_d = dm_wdata;
                    wd_start_s  = 1'b1;
                end else if (if_req && !i_done_q) begin
                    state_d    = ST_IBUS;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = SEL_ALL;
                    bus_addr_d = if_addr;
                    wd_start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DBUS: begin
                if (cmpl_s) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    if (!bus_we_q) begin
                        dm_rdata_d = rdata_s;
                    end else begin
                        dm_rdata_d = dm_rdata_q;
                    end
                end else begin
                    state_d = ST_DBUS;
                end
            end
            ST_IBUS: begin
                if (cmpl_s) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    if_inst_d = rdata_s;
                end else begin
                    state_d = ST_IBUS;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase

        if (cmpl_s && !bus.ack) begin
            bus_err_d = 1'b1;
        end else begin
            bus_err_d = bus_err_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'h0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_inst_q   <= '0;
            dm_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            i_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_inst_q   <= if_inst_d;
            dm_rdata_q  <= dm_rdata_d;
            d_done_q    <= d_done_d;
            i_done_q    <= i_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.req      = bus_req_q;
    assign bus.we       = bus_we_q;
    assign bus.sel      = bus_sel_q;
    assign bus.addr     = bus_addr_q;
    assign bus.wdata    = bus_wdata_q;
    assign if_inst      = if_inst_q;
    assign dm_rdata     = dm_rdata_q;
    assign bus_err      = bus_err_q;
    assign dm_stall_req = dm_req && !d_done_q;
    assign if_stall_req = if_req && !i_done_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: expected bus transfers and results
// are queued as requests are raised and checked as the memory side serves them.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_stall_req;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_sel;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_stall_req;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AW(32), .DW(32)) bus_if ();

    mem_bus_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(4), .TOW(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_inst      (if_inst),
        .if_stall_req (if_stall_req),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_sel       (dm_sel),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata),
        .dm_stall_req (dm_stall_req),
        .bus          (bus_if),
        .bus_err      (bus_err)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] exp_inst = 32'h0;
    logic [31:0] exp_drd  = 32'h0;
    int          waited;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] rdata);
        txn_t t;
        t = '{is_data: 1'b0, we: 1'b0, sel: 4'hF, addr: addr, wdata: 32'h0, rdata: rdata};
        exp_q.push_back(t);
    endtask

    task automatic push_data(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata);
        txn_t t;
        t = '{is_data: 1'b1, we: we, sel: sel, addr: addr, wdata: wdata, rdata: rdata};
        exp_q.push_back(t);
    endtask

    // Wait for a bus request, check it against the scoreboard, ack after
    // 'delay' cycles (0 = never ack) and check the resulting registers.
    task automatic serve(input int delay, input int exp_hi, output int wait_cyc);
        txn_t        t;
        int          hi;
        logic [31:0] result;
        wait_cyc = 0;
        while (bus_if.req !== 1'b1 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        check_eq("req_seen", {31'h0, bus_if.req}, 32'h1);
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL sb_empty: got a bus request, want none queued");
            return;
        end
        t = exp_q.pop_front();
        check_eq("bus_we", {31'h0, bus_if.we}, {31'h0, t.we});
        check_eq("bus_sel", {28'h0, bus_if.sel}, {28'h0, t.sel});
        check_eq("bus_addr", bus_if.addr, t.addr);
        if (t.is_data && t.we) check_eq("bus_wdata", bus_if.wdata, t.wdata);
        hi = 1;
        if (delay == 0) begin
            while (bus_if.req === 1'b1 && hi < 20) begin
                step();
                if (bus_if.req === 1'b1) hi++;
            end
            result = 32'h0;
        end else begin
            for (int i = 1; i < delay; i++) begin
                step();
                if (bus_if.req === 1'b1) hi++;
                check_eq("hold_addr", bus_if.addr, t.addr);
            end
            bus_if.ack   = 1'b1;
            bus_if.rdata = t.rdata;
            step();
            bus_if.ack   = 1'b0;
            bus_if.rdata = 32'h0;
            result = t.rdata;
        end
        check_eq("req_drop", {31'h0, bus_if.req}, 32'h0);
        check_eq("req_cycles", hi, exp_hi);
        if (t.is_data) begin
            if (!t.we) exp_drd = result;
            check_eq("dm_stall_done", {31'h0, dm_stall_req}, 32'h0);
        end else begin
            exp_inst = result;
            check_eq("if_stall_done", {31'h0, if_stall_req}, 32'h0);
        end
        check_eq("dm_rdata", dm_rdata, exp_drd);
        check_eq("if_inst", if_inst, exp_inst);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b0; stall_i = 6'h0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_sel = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
        repeat (3) step();
        check_eq("rst_bus_req", {31'h0, bus_if.req}, 32'h0);
        check_eq("rst_if_inst", if_inst, 32'h0);
        check_eq("rst_dm_rdata", dm_rdata, 32'h0);
        check_eq("rst_bus_err", {31'h0, bus_err}, 32'h0);
        rst = 1'b1;
        step();

        // 1: fetch only, ack after 2 cycles
        if_req = 1'b1; if_addr = 32'h0000_0010;
        push_fetch(32'h0000_0010, 32'h3401_0020);
        serve(2, 2, waited);
        check_eq("t1_latency", waited, 1);
        if_req = 1'b0;
        step();

        // 2: collision, data first then fetch after one idle cycle
        if_req = 1'b1; if_addr = 32'h0000_0020;
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0100;
        push_data(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        push_fetch(32'h0000_0020, 32'h0000_0013);
        serve(1, 1, waited);
        dm_req = 1'b0;
        serve(1, 1, waited);
        check_eq("t2_idle_gap", waited, 1);
        if_req = 1'b0;
        step();

        // 3: write with MEM stage held
        stall_i = 6'b010000;
        dm_req = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011;
        dm_addr = 32'h0000_0200; dm_wdata = 32'h1234_5678;
        push_data(1'b1, 4'b0011, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_FFFF);
        serve(3, 3, waited);
        repeat (2) begin
            step();
            check_eq("t3_held_req", {31'h0, bus_if.req}, 32'h0);
            check_eq("t3_held_stall", {31'h0, dm_stall_req}, 32'h0);
        end
        stall_i = 6'h0;
        step();
        check_eq("t3_done_clr", {31'h0, dm_stall_req}, 32'h1);
        dm_req = 1'b0;
        step();
        check_eq("t3_no_retry", {31'h0, bus_if.req}, 32'h0);

        // 4: held fetch result while IF is stalled
        stall_i = 6'b000010;
        if_req = 1'b1; if_addr = 32'h0000_0030;
        push_fetch(32'h0000_0030, 32'hCAFE_0001);
        serve(1, 1, waited);
        repeat (5) begin
            step();
            check_eq("t4_no_fetch", {31'h0, bus_if.req}, 32'h0);
            check_eq("t4_stall", {31'h0, if_stall_req}, 32'h0);
            check_eq("t4_inst", if_inst, exp_inst);
        end
        if_addr = 32'h0000_0034;
        push_fetch(32'h0000_0034, 32'hCAFE_0002);
        stall_i = 6'h0;
        step();
        check_eq("t4_release_req", {31'h0, bus_if.req}, 32'h0);
        check_eq("t4_release_stall", {31'h0, if_stall_req}, 32'h1);
        serve(1, 1, waited);
        check_eq("t4_restart", waited, 1);
        if_req = 1'b0;
        step();

        // 5: watchdog timeout, no ack ever
        if_req = 1'b1; if_addr = 32'h0000_0040;
        push_fetch(32'h0000_0040, 32'hBAD0_BAD0);
        serve(0, 4, waited);
        check_eq("t5_err", {31'h0, bus_err}, 32'h1);
        if_req = 1'b0;
        repeat (3) step();
        check_eq("t5_err_sticky", {31'h0, bus_err}, 32'h1);

        // 6: reset mid data transfer, then a stray ack in idle
        dm_req = 1'b1; dm_we = 1'b0; dm_sel = 4'hF; dm_addr = 32'h0000_0300;
        step();
        check_eq("t6_req", {31'h0, bus_if.req}, 32'h1);
        check_eq("t6_addr", bus_if.addr, 32'h0000_0300);
        step();
        rst = 1'b0; dm_req = 1'b0;
        step();
        rst = 1'b1;
        exp_drd = 32'h0; exp_inst = 32'h0;
        check_eq("t6_rst_req", {31'h0, bus_if.req}, 32'h0);
        check_eq("t6_rst_err", {31'h0, bus_err}, 32'h0);
        check_eq("t6_rst_drd", dm_rdata, exp_drd);
        check_eq("t6_rst_inst", if_inst, exp_inst);
        bus_if.ack = 1'b1; bus_if.rdata = 32'h5555_5555;
        step();
        bus_if.ack = 1'b0; bus_if.rdata = 32'h0;
        check_eq("t6_stray_req", {31'h0, bus_if.req}, 32'h0);
        check_eq("t6_stray_drd", dm_rdata, exp_drd);
        check_eq("t6_stray_inst", if_inst, exp_inst);
        step();
        check_eq("t6_idle", {31'h0, bus_if.req}, 32'h0);
        check_eq("sb_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
